// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prog_sequencer
// Brief    : Four-phase run controller driving a fetch unit's Init/ProgState
//            and timing its Halt flag against a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MASK_CYCLES = 1,
  parameter int unsigned MAX_CYCLES  = 16'hFFFF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Req,
  input  logic [1:0]       ProgNum,
  input  logic             Halt,
  input  logic [9:0]       PC,
  output logic             Init,
  output logic [1:0]       ProgState,
  output logic             Busy,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount,
  output logic [9:0]       FinalPC,
  output logic             Timeout,
  output logic             Error
);

  localparam int unsigned      INIT_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [1:0]       c_prog_none = 2'b11;
  localparam logic [INIT_W-1:0] c_init_last = INIT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_mask      = CNT_W'(MASK_CYCLES);
  localparam logic [CNT_W-1:0] c_max       = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [INIT_W-1:0] r_init_cnt, w_init_cnt;
  logic [1:0]        r_prog_sel, w_prog_sel;
  logic [CNT_W-1:0]  w_count;
  logic [9:0]        w_final_pc;
  logic              w_timeout;
  logic              w_error;
  logic              w_busy;

  always_comb begin
    w_state    = r_state;
    w_init_cnt = r_init_cnt;
    w_prog_sel = r_prog_sel;
    w_count    = CycleCount;
    w_final_pc = FinalPC;
    w_timeout  = Timeout;
    w_error    = Error;

    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_timeout  = 1'b0;
          w_count    = '0;
          w_init_cnt = '0;
          if (ProgNum != c_prog_none) begin
            w_prog_sel = ProgNum;
            w_error    = 1'b0;
            w_state    = S_INIT;
          end else begin
            w_error    = 1'b1;
            w_state    = S_DONE;
          end
        end
      end
      S_INIT: begin
        if (r_init_cnt == c_init_last) begin
          w_count = CNT_W'(1);
          w_state = S_RUN;
        end else begin
          w_init_cnt = r_init_cnt + INIT_W'(1);
        end
      end
      S_RUN: begin
        // A qualifying Halt takes priority over the watchdog in the same cycle
        if (Halt && (CycleCount > c_mask)) begin
          w_final_pc = PC;
          w_state    = S_DONE;
        end else if (CycleCount >= c_max) begin
          w_final_pc = PC;
          w_timeout  = 1'b1;
          w_state    = S_DONE;
        end else if (CycleCount != '1) begin
          w_count = CycleCount + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!Req) begin
          w_state = S_RELEASE;
        end
      end
      S_RELEASE: w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase

    w_busy = (w_state == S_INIT) || (w_state == S_RUN);
  end

  // Outputs are decoded from the next state so they are registered
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_init_cnt <= '0;
      r_prog_sel <= c_prog_none;
      Init       <= 1'b0;
      ProgState  <= c_prog_none;
      Busy       <= 1'b0;
      Ack        <= 1'b0;
      CycleCount <= '0;
      FinalPC    <= '0;
      Timeout    <= 1'b0;
      Error      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_init_cnt <= w_init_cnt;
      r_prog_sel <= w_prog_sel;
      Init       <= (w_state == S_INIT);
      ProgState  <= w_busy ? w_prog_sel : c_prog_none;
      Busy       <= w_busy;
      Ack        <= (w_state == S_DONE);
      CycleCount <= w_count;
      FinalPC    <= w_final_pc;
      Timeout    <= w_timeout;
      Error      <= w_error;
    end
  end

endmodule
`default_nettype wire
